wb_drain_buffer: RTL and testbench
==================================

Name: wb_drain_buffer

Overview:
- Writeback buffer directly upstream of the architectural register file write port.
- Collects completed results from the ALU and load/store units and queues them in arrival order.
- Drains at most one result per cycle into the register file's write-enable/select/data inputs.
- Provides a two-port bypass lookup so operand reads see results still pending in the buffer.

Parameters:
DATA_WIDTH, 32, width of result data (matches register file data width)
SEL_BITS, 5, register index width
DEPTH, 4, buffer entries; power of two, >= 2

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset; clears all state
alu_valid  in  1  ALU result valid
alu_rd  in  SEL_BITS  ALU destination register
alu_data  in  DATA_WIDTH  ALU result
alu_ready  out  1  buffer can accept an ALU result this cycle
mem_valid  in  1  load result valid
mem_rd  in  SEL_BITS  load destination register
mem_data  in  DATA_WIDTH  load result
mem_ready  out  1  buffer can accept a load result this cycle
drain_stall  in  1  hold the head entry (register file port borrowed)
wEn  out  1  register file write enable
write_sel  out  SEL_BITS  register file write index
write_data  out  DATA_WIDTH  register file write data
lookup_sel1  in  SEL_BITS  bypass query 1
lookup_sel2  in  SEL_BITS  bypass query 2
hit1  out  1  query 1 matches a pending entry
hit2  out  1  query 2 matches a pending entry
lookup_data1  out  DATA_WIDTH  youngest matching pending data for query 1
lookup_data2  out  DATA_WIDTH  youngest matching pending data for query 2
count  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Storage: circular buffer of DEPTH entries {rd, data}, head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
- Reset (reset==0, asynchronous): head=tail=count=0. wEn=0, write_sel=0, write_data=0, hit1=hit2=0, lookup_data1/2=0. Entries need not be cleared. Reset asserted mid-operation discards all pending entries, with no partial drain.
- Ready: alu_ready = mem_ready = (DEPTH - count >= 2). The check is conservative so both sources can always enqueue in the same cycle. It depends only on registered state; it never depends on the valid inputs.
- Enqueue at the rising edge when valid & ready:
  - If both sources are accepted in the same cycle, the mem entry goes to tail and the ALU entry to tail+1. Loads are treated as older.
  - A result with rd==0 is accepted (ready honoured) but not stored. It consumes no slot.
- Drain outputs are combinational from registered state:
  - wEn = (count!=0) & !drain_stall.
  - write_sel/write_data = head entry when count!=0, else 0.
  - The head pops at the edge when wEn=1. The register file always accepts.
- Latency: a result accepted at edge N into an empty buffer drives wEn=1 during cycle N+1 and is written to the register file at edge N+1.
- Occupancy: count_next = count + enq_n - (wEn ? 1 : 0), where enq_n is 0..2. A simultaneous enqueue and dequeue is legal, including at count==DEPTH-2.
- Full: count > DEPTH-2 forces both readys low. Valid asserted while not ready is ignored, and the producer must hold it.
- Empty: wEn=0; drain_stall has no effect.
- Bypass:
  - hitK=1 if any occupied entry has rd==lookup_selK, and lookup_dataK is the youngest such entry's data (closest to tail). Otherwise hitK=0 and data=0.
  - lookup_selK==0 always gives hitK=0.
  - Entries being enqueued in the current cycle are not visible. The head entry being drained this cycle is still visible.
- Ordering guarantee: two writes to the same rd reach the register file in acceptance order.

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles, then release. Required: wEn=0, count=0, alu_ready=mem_ready=1, hit1=hit2=0.
- Single ALU write: alu rd=5, data=0xDEADBEEF at edge 1. Required: cycle 2 shows wEn=1, write_sel=5, write_data=0xDEADBEEF; count returns to 0 after edge 2.
- Dual enqueue ordering: same-cycle mem rd=3/0x11 and alu rd=3/0x22. Required: lookup_sel1=3 gives hit1=1, data 0x22. The drain order is 0x11 then 0x22 on consecutive cycles.
- Full/backpressure, DEPTH=4: drain_stall=1, enqueue 2+1 entries. Required: count=3, readys=0; a further alu_valid is ignored. Releasing the stall drains 3 writes in order.
- x0 and wrap-around: alu rd=0/0x99 gives count unchanged, no wEn, hit for sel 0 stays 0. Pushing 10 entries through continuously with head/tail wrapping gives all 10 writes in order, with no loss or duplication.
- Reset mid-operation: with count=3, pull reset low asynchronously between edges. Required: wEn=0 and count=0 immediately; no stale write appears after release.

Source files
------------

// File: rtl/wb_drain_buffer.sv
// Writeback drain buffer: queues ALU and load results in arrival order and
// drains one per cycle into the register file, with a two-port pending-result bypass.
module wb_drain_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_BITS   = 5,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [SEL_BITS-1:0]        alu_rd,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [SEL_BITS-1:0]        mem_rd,
  input  logic [DATA_WIDTH-1:0]      mem_data,
  output logic                       mem_ready,
  input  logic                       drain_stall,
  output logic                       wEn,
  output logic [SEL_BITS-1:0]        write_sel,
  output logic [DATA_WIDTH-1:0]      write_data,
  input  logic [SEL_BITS-1:0]        lookup_sel1,
  input  logic [SEL_BITS-1:0]        lookup_sel2,
  output logic                       hit1,
  output logic                       hit2,
  output logic [DATA_WIDTH-1:0]      lookup_data1,
  output logic [DATA_WIDTH-1:0]      lookup_data2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [SEL_BITS-1:0]   rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [CNT_W-1:0]      count_q;

  logic                  accept_ok;
  logic                  mem_store;
  logic                  alu_store;
  logic [PTR_W-1:0]      alu_slot;
  logic [CNT_W-1:0]      enq_n;
  logic                  occupied;

  // Two free slots are required so both producers can always land together.
  assign accept_ok = (count_q <= CNT_W'(DEPTH - 2));
  assign alu_ready = accept_ok;
  assign mem_ready = accept_ok;

  // x0 results are acknowledged but never occupy a slot.
  assign mem_store = mem_valid & accept_ok & (mem_rd != '0);
  assign alu_store = alu_valid & accept_ok & (alu_rd != '0);
  assign alu_slot  = mem_store ? tail_q + PTR_W'(1) : tail_q;
  assign enq_n     = CNT_W'(mem_store) + CNT_W'(alu_store);

  assign occupied   = (count_q != '0);
  assign wEn        = occupied & ~drain_stall;
  assign write_sel  = occupied ? rd_q[head_q]   : '0;
  assign write_data = occupied ? data_q[head_q] : '0;
  assign count      = count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (wEn) begin
        head_q <= head_q + PTR_W'(1);
      end
      tail_q  <= tail_q + PTR_W'(enq_n);
      count_q <= count_q + enq_n - CNT_W'(wEn);
    end
  end

  // Entry storage carries no reset; occupancy alone qualifies its contents.
  always_ff @(posedge clock) begin
    if (mem_store) begin
      rd_q[tail_q]   <= mem_rd;
      data_q[tail_q] <= mem_data;
    end
    if (alu_store) begin
      rd_q[alu_slot]   <= alu_rd;
      data_q[alu_slot] <= alu_data;
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest pending value.
  always_comb begin
    hit1         = 1'b0;
    hit2         = 1'b0;
    lookup_data1 = '0;
    lookup_data2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        if (lookup_sel1 != '0 && rd_q[head_q + PTR_W'(i)] == lookup_sel1) begin
          hit1         = 1'b1;
          lookup_data1 = data_q[head_q + PTR_W'(i)];
        end
        if (lookup_sel2 != '0 && rd_q[head_q + PTR_W'(i)] == lookup_sel2) begin
          hit2         = 1'b1;
          lookup_data2 = data_q[head_q + PTR_W'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_drain_buffer.sv
// Directed self-checking bench for wb_drain_buffer (DEPTH=4).
module tb_wb_drain_buffer;

  logic        clock;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        drain_stall;
  logic        wEn;
  logic [4:0]  write_sel;
  logic [31:0] write_data;
  logic [4:0]  lookup_sel1;
  logic [4:0]  lookup_sel2;
  logic        hit1;
  logic        hit2;
  logic [31:0] lookup_data1;
  logic [31:0] lookup_data2;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  wb_drain_buffer #(
    .DATA_WIDTH(32),
    .SEL_BITS(5),
    .DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .alu_valid(alu_valid),
    .alu_rd(alu_rd),
    .alu_data(alu_data),
    .alu_ready(alu_ready),
    .mem_valid(mem_valid),
    .mem_rd(mem_rd),
    .mem_data(mem_data),
    .mem_ready(mem_ready),
    .drain_stall(drain_stall),
    .wEn(wEn),
    .write_sel(write_sel),
    .write_data(write_data),
    .lookup_sel1(lookup_sel1),
    .lookup_sel2(lookup_sel2),
    .hit1(hit1),
    .hit2(hit2),
    .lookup_data1(lookup_data1),
    .lookup_data2(lookup_data2),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    drain_stall = 1'b0; lookup_sel1 = '0; lookup_sel2 = '0;

    // Reset and idle
    tick(); tick(); tick();
    check("rst_wen", 32'(wEn), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    reset = 1'b1;
    #1;
    check("idle_wen", 32'(wEn), 32'd0);
    check("idle_count", 32'(count), 32'd0);
    check("idle_alu_ready", 32'(alu_ready), 32'd1);
    check("idle_mem_ready", 32'(mem_ready), 32'd1);
    check("idle_hit1", 32'(hit1), 32'd0);
    check("idle_hit2", 32'(hit2), 32'd0);
    check("idle_wsel", 32'(write_sel), 32'd0);
    check("idle_wdata", write_data, 32'd0);

    // Single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    #1;
    check("single_wen", 32'(wEn), 32'd1);
    check("single_wsel", 32'(write_sel), 32'd5);
    check("single_wdata", write_data, 32'hDEADBEEF);
    check("single_count1", 32'(count), 32'd1);
    tick();
    check("single_count0", 32'(count), 32'd0);
    check("single_wen_off", 32'(wEn), 32'd0);

    // Dual enqueue, same rd: load is older
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22;
    lookup_sel1 = 5'd3;
    #1;
    check("dual_hit_pre", 32'(hit1), 32'd0);
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    #1;
    check("dual_count", 32'(count), 32'd2);
    check("dual_hit1", 32'(hit1), 32'd1);
    check("dual_data1", lookup_data1, 32'h22);
    check("dual_drain0", write_data, 32'h11);
    check("dual_wen0", 32'(wEn), 32'd1);
    tick();
    check("dual_drain1", write_data, 32'h22);
    check("dual_wsel1", 32'(write_sel), 32'd3);
    check("dual_hit_head", 32'(hit1), 32'd1);
    tick();
    check("dual_count0", 32'(count), 32'd0);
    check("dual_hit_gone", 32'(hit1), 32'd0);

    // Full and backpressure
    drain_stall = 1'b1;
    mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'hA1;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hA2;
    tick();
    mem_valid = 1'b0;
    alu_rd = 5'd4; alu_data = 32'hA4;
    #1;
    check("full_count2", 32'(count), 32'd2);
    check("full_stall_wen", 32'(wEn), 32'd0);
    check("full_ready2", 32'(alu_ready), 32'd1);
    tick();
    alu_rd = 5'd6; alu_data = 32'hA6;
    #1;
    check("full_count3", 32'(count), 32'd3);
    check("full_alu_ready", 32'(alu_ready), 32'd0);
    check("full_mem_ready", 32'(mem_ready), 32'd0);
    tick();
    alu_valid = 1'b0;
    lookup_sel2 = 5'd6;
    #1;
    check("full_ignored_count", 32'(count), 32'd3);
    check("full_ignored_hit", 32'(hit2), 32'd0);
    lookup_sel2 = 5'd2;
    #1;
    check("full_hit2", 32'(hit2), 32'd1);
    check("full_data2", lookup_data2, 32'hA2);
    drain_stall = 1'b0;
    #1;
    check("full_drain0_wen", 32'(wEn), 32'd1);
    check("full_drain0", write_data, 32'hA1);
    tick();
    check("full_drain1", write_data, 32'hA2);
    tick();
    check("full_drain2", write_data, 32'hA4);
    check("full_drain2_sel", 32'(write_sel), 32'd4);
    tick();
    check("full_empty", 32'(count), 32'd0);
    check("full_empty_wen", 32'(wEn), 32'd0);

    // x0 result is acknowledged but dropped
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h99;
    lookup_sel1 = 5'd0;
    #1;
    check("x0_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    #1;
    check("x0_count", 32'(count), 32'd0);
    check("x0_wen", 32'(wEn), 32'd0);
    check("x0_hit", 32'(hit1), 32'd0);

    // Ten results streamed through, alternating sources, pointers wrap
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        mem_valid = 1'b1; mem_rd = 5'(i + 1); mem_data = 32'h100 + 32'(i);
        alu_valid = 1'b0;
      end else begin
        alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = 32'h100 + 32'(i);
        mem_valid = 1'b0;
      end
      tick();
      check("wrap_wen", 32'(wEn), 32'd1);
      check("wrap_data", write_data, 32'h100 + 32'(i));
      check("wrap_sel", 32'(write_sel), 32'(i + 1));
      check("wrap_count", 32'(count), 32'd1);
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    tick();
    check("wrap_done_count", 32'(count), 32'd0);
    check("wrap_done_wen", 32'(wEn), 32'd0);

    // Asynchronous reset with entries pending
    drain_stall = 1'b1;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hB7;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'hB8;
    tick();
    mem_valid = 1'b0;
    alu_rd = 5'd9; alu_data = 32'hB9;
    tick();
    alu_valid = 1'b0;
    drain_stall = 1'b0;
    lookup_sel1 = 5'd7;
    #1;
    check("mid_count3", 32'(count), 32'd3);
    check("mid_wen_pre", 32'(wEn), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_wen_rst", 32'(wEn), 32'd0);
    check("mid_count_rst", 32'(count), 32'd0);
    check("mid_hit_rst", 32'(hit1), 32'd0);
    check("mid_wdata_rst", write_data, 32'd0);
    tick();
    #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_wen", 32'(wEn), 32'd0);
      check("post_rst_count", 32'(count), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
